// File: rtl/te_block_serializer.sv
// Trace block serializer: queues up to N blocks per cycle and hands them one at a time to the encoder.
// Optional TE_SERIALIZER_DROP_CNT_EN adds a saturating 16-bit dropped-block counter on drop_cnt_o.
package mure_pkg;
  localparam int XLEN        = 32;
  localparam int IRETIRE_LEN = 32;
  localparam int ITYPE_LEN   = 3;
  localparam int CAUSE_LEN   = 5;
  localparam int PRIV_LEN    = 2;
endpackage

module te_block_serializer
  import mure_pkg::*;
#(
  parameter int N     = 1,
  parameter int DEPTH = 8
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [N-1:0]                  valid_i,
  input  logic [N*IRETIRE_LEN-1:0]      iretire_i,
  input  logic [N-1:0]                  ilastsize_i,
  input  logic [N*ITYPE_LEN-1:0]        itype_i,
  input  logic [N*CAUSE_LEN-1:0]        cause_i,
  input  logic [N*XLEN-1:0]             tval_i,
  input  logic [N*PRIV_LEN-1:0]         priv_i,
  input  logic [N*XLEN-1:0]             iaddr_i,
  output logic                          valid_o,
  input  logic                          ready_i,
  output logic [IRETIRE_LEN-1:0]        iretire_o,
  output logic                          ilastsize_o,
  output logic [ITYPE_LEN-1:0]          itype_o,
  output logic [CAUSE_LEN-1:0]          cause_o,
  output logic [XLEN-1:0]               tval_o,
  output logic [PRIV_LEN-1:0]           priv_o,
  output logic [XLEN-1:0]               iaddr_o,
  output logic [$clog2(DEPTH):0]        usage_o,
  output logic                          full_o,
  output logic                          overflow_o
`ifdef TE_SERIALIZER_DROP_CNT_EN
  ,
  output logic [15:0]                   drop_cnt_o
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int UW = PW + 1;

  typedef struct packed {
    logic [IRETIRE_LEN-1:0] iretire;
    logic                   ilastsize;
    logic [ITYPE_LEN-1:0]   itype;
    logic [CAUSE_LEN-1:0]   cause;
    logic [XLEN-1:0]        tval;
    logic [PRIV_LEN-1:0]    priv;
    logic [XLEN-1:0]        iaddr;
  } blk_t;

  blk_t          mem [DEPTH];
  blk_t          lane_blk [N];
  logic [PW-1:0] slot [N];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [UW-1:0] usage_q;
  logic [UW-1:0] k;
  logic          overflow_q;
  logic          accept, pop;
  blk_t          head;

  // Compaction: each valid lane lands at wr_ptr plus the number of valid lanes below it.
  always_comb begin
    k = '0;
    for (int i = 0; i < N; i++) begin
      lane_blk[i].iretire   = iretire_i[i*IRETIRE_LEN +: IRETIRE_LEN];
      lane_blk[i].ilastsize = ilastsize_i[i];
      lane_blk[i].itype     = itype_i[i*ITYPE_LEN +: ITYPE_LEN];
      lane_blk[i].cause     = cause_i[i*CAUSE_LEN +: CAUSE_LEN];
      lane_blk[i].tval      = tval_i[i*XLEN +: XLEN];
      lane_blk[i].priv      = priv_i[i*PRIV_LEN +: PRIV_LEN];
      lane_blk[i].iaddr     = iaddr_i[i*XLEN +: XLEN];
      slot[i]               = wr_ptr + k[PW-1:0];
      k                     = k + UW'(valid_i[i]);
    end
  end

  // Space is judged on registered occupancy only, so a same-cycle pop never admits a push.
  assign accept = (k <= (UW'(DEPTH) - usage_q));
  assign valid_o = (usage_q != '0);
  assign pop     = valid_o && ready_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      usage_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + k[PW-1:0];
      rd_ptr     <= rd_ptr + PW'(pop);
      usage_q    <= usage_q + (accept ? k : '0) - UW'(pop);
      overflow_q <= !accept;
    end
  end

  // Storage is not reset; the head is gated by valid_o instead.
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < N; i++) begin
      if (accept && valid_i[i]) mem[slot[i]] <= lane_blk[i];
    end
  end

  assign head        = valid_o ? mem[rd_ptr] : '0;
  assign iretire_o   = head.iretire;
  assign ilastsize_o = head.ilastsize;
  assign itype_o     = head.itype;
  assign cause_o     = head.cause;
  assign tval_o      = head.tval;
  assign priv_o      = head.priv;
  assign iaddr_o     = head.iaddr;
  assign usage_o     = usage_q;
  assign full_o      = (usage_q == UW'(DEPTH));
  assign overflow_o  = overflow_q;

`ifdef TE_SERIALIZER_DROP_CNT_EN
  logic [15:0] drop_cnt_q;

  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [UW-1:0] b);
    logic [16:0] s;
    s = {1'b0, a} + 17'(b);
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) drop_cnt_q <= '0;
    else if (!accept) drop_cnt_q <= sat_add16(drop_cnt_q, k);
  end

  assign drop_cnt_o = drop_cnt_q;
`endif

endmodule

// File: tb/tb_te_block_serializer.sv
// Scoreboard bench for te_block_serializer (N=2, DEPTH=8): directed plan cases plus randomized traffic
// compared against a queue-based reference model.
module tb_te_block_serializer;
  import mure_pkg::*;

  localparam int N     = 2;
  localparam int DEPTH = 8;
  localparam int UW    = $clog2(DEPTH) + 1;

  logic                     clk = 1'b0;
  logic                     rst_n = 1'b0;
  logic [N-1:0]             valid_i = '0;
  logic [N*IRETIRE_LEN-1:0] iretire_i = '0;
  logic [N-1:0]             ilastsize_i = '0;
  logic [N*ITYPE_LEN-1:0]   itype_i = '0;
  logic [N*CAUSE_LEN-1:0]   cause_i = '0;
  logic [N*XLEN-1:0]        tval_i = '0;
  logic [N*PRIV_LEN-1:0]    priv_i = '0;
  logic [N*XLEN-1:0]        iaddr_i = '0;
  logic                     ready_i = 1'b0;
  logic                     valid_o;
  logic [IRETIRE_LEN-1:0]   iretire_o;
  logic                     ilastsize_o;
  logic [ITYPE_LEN-1:0]     itype_o;
  logic [CAUSE_LEN-1:0]     cause_o;
  logic [XLEN-1:0]          tval_o;
  logic [PRIV_LEN-1:0]      priv_o;
  logic [XLEN-1:0]          iaddr_o;
  logic [UW-1:0]            usage_o;
  logic                     full_o;
  logic                     overflow_o;
`ifdef TE_SERIALIZER_DROP_CNT_EN
  logic [15:0]              drop_cnt_o;
`endif

  te_block_serializer #(.N(N), .DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_ni(rst_n), .valid_i(valid_i),
    .iretire_i(iretire_i), .ilastsize_i(ilastsize_i), .itype_i(itype_i),
    .cause_i(cause_i), .tval_i(tval_i), .priv_i(priv_i), .iaddr_i(iaddr_i),
    .valid_o(valid_o), .ready_i(ready_i),
    .iretire_o(iretire_o), .ilastsize_o(ilastsize_o), .itype_o(itype_o),
    .cause_o(cause_o), .tval_o(tval_o), .priv_o(priv_o), .iaddr_o(iaddr_o),
    .usage_o(usage_o), .full_o(full_o), .overflow_o(overflow_o)
`ifdef TE_SERIALIZER_DROP_CNT_EN
    , .drop_cnt_o(drop_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [IRETIRE_LEN-1:0] iretire;
    logic                   ilastsize;
    logic [ITYPE_LEN-1:0]   itype;
    logic [CAUSE_LEN-1:0]   cause;
    logic [XLEN-1:0]        tval;
    logic [PRIV_LEN-1:0]    priv;
    logic [XLEN-1:0]        iaddr;
  } rec_t;

  int   total = 0;
  int   bad = 0;
  rec_t expq[$];
  logic exp_ovf = 1'b0;
  int   exp_drop = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic rec_t lane_rec(input int i);
    rec_t r;
    r.iretire   = iretire_i[i*IRETIRE_LEN +: IRETIRE_LEN];
    r.ilastsize = ilastsize_i[i];
    r.itype     = itype_i[i*ITYPE_LEN +: ITYPE_LEN];
    r.cause     = cause_i[i*CAUSE_LEN +: CAUSE_LEN];
    r.tval      = tval_i[i*XLEN +: XLEN];
    r.priv      = priv_i[i*PRIV_LEN +: PRIV_LEN];
    r.iaddr     = iaddr_i[i*XLEN +: XLEN];
    return r;
  endfunction

  function automatic rec_t head_rec();
    rec_t r;
    r.iretire = iretire_o; r.ilastsize = ilastsize_o; r.itype = itype_o;
    r.cause = cause_o; r.tval = tval_o; r.priv = priv_o; r.iaddr = iaddr_o;
    return r;
  endfunction

  function automatic rec_t rand_rec();
    rec_t r;
    r.iretire   = IRETIRE_LEN'($urandom);
    r.ilastsize = 1'($urandom);
    r.itype     = ITYPE_LEN'($urandom);
    r.cause     = CAUSE_LEN'($urandom);
    r.tval      = XLEN'($urandom);
    r.priv      = PRIV_LEN'($urandom);
    r.iaddr     = XLEN'($urandom);
    return r;
  endfunction

  task automatic set_lane(input int i, input rec_t r);
    iretire_i[i*IRETIRE_LEN +: IRETIRE_LEN] = r.iretire;
    ilastsize_i[i]                          = r.ilastsize;
    itype_i[i*ITYPE_LEN +: ITYPE_LEN]       = r.itype;
    cause_i[i*CAUSE_LEN +: CAUSE_LEN]       = r.cause;
    tval_i[i*XLEN +: XLEN]                  = r.tval;
    priv_i[i*PRIV_LEN +: PRIV_LEN]          = r.priv;
    iaddr_i[i*XLEN +: XLEN]                 = r.iaddr;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Reference model: a FIFO of records with all-or-nothing admission against start-of-cycle space.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      expq.delete();
      exp_ovf  = 1'b0;
      exp_drop = 0;
    end else begin
      int k;
      int space;
      bit do_pop;
      k = 0;
      for (int i = 0; i < N; i++) k += int'(valid_i[i]);
      space  = DEPTH - expq.size();
      do_pop = (expq.size() != 0) && ready_i;
      if (do_pop) void'(expq.pop_front());
      if (k <= space) begin
        for (int i = 0; i < N; i++) if (valid_i[i]) expq.push_back(lane_rec(i));
        exp_ovf = 1'b0;
      end else begin
        exp_ovf  = 1'b1;
        exp_drop = (exp_drop + k > 65535) ? 65535 : exp_drop + k;
      end
    end
  end

  // Monitor: compare whatever the DUT presents against the model, away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("valid_o", 128'(valid_o), 128'(expq.size() != 0));
      chk("usage_o", 128'(usage_o), 128'(expq.size()));
      chk("full_o", 128'(full_o), 128'(expq.size() == DEPTH));
      chk("overflow_o", 128'(overflow_o), 128'(exp_ovf));
      if (expq.size() != 0) chk("head", 128'(head_rec()), 128'(expq[0]));
      else chk("idle_head", 128'(head_rec()), 128'(0));
`ifdef TE_SERIALIZER_DROP_CNT_EN
      chk("drop_cnt_o", 128'(drop_cnt_o), 128'(exp_drop));
`endif
    end
  end

  initial begin
    rec_t r;
    logic [XLEN-1:0] held_iaddr;
    logic [ITYPE_LEN-1:0] held_itype;

    repeat (3) @(negedge clk);
    chk("rst_valid", 128'(valid_o), 128'(0));
    chk("rst_usage", 128'(usage_o), 128'(0));
    chk("rst_overflow", 128'(overflow_o), 128'(0));
    chk("rst_iaddr", 128'(iaddr_o), 128'(0));
    rst_n = 1'b1;

    // Single push on lane 1
    r = '0; r.iaddr = 32'h8000_0010; r.itype = 3'd4;
    set_lane(1, r); valid_i = 2'b10; ready_i = 1'b1;
    step();
    chk("single_valid", 128'(valid_o), 128'(1));
    chk("single_iaddr", 128'(iaddr_o), 128'(32'h8000_0010));
    valid_i = '0;
    step();
    chk("single_empty", 128'(valid_o), 128'(0));
    chk("single_usage", 128'(usage_o), 128'(0));

    // Lane ordering: exception block in lane 0 leaves first
    r = '0; r.itype = 3'd1; r.cause = 5'h2; r.tval = 32'hDEAD; set_lane(0, r);
    r = '0; r.itype = 3'd4; r.iaddr = 32'h100; set_lane(1, r);
    valid_i = 2'b11;
    step();
    valid_i = '0;
    chk("order0_itype", 128'(itype_o), 128'(1));
    chk("order0_cause", 128'(cause_o), 128'(2));
    chk("order0_tval", 128'(tval_o), 128'(32'hDEAD));
    step();
    chk("order1_itype", 128'(itype_o), 128'(4));
    chk("order1_iaddr", 128'(iaddr_o), 128'(32'h100));
    step();

    // Back-pressure: three blocks held for five cycles, then drained
    ready_i = 1'b0;
    set_lane(0, rand_rec()); set_lane(1, rand_rec()); valid_i = 2'b11;
    step();
    set_lane(0, rand_rec()); valid_i = 2'b01;
    step();
    valid_i = '0;
    held_iaddr = iaddr_o; held_itype = itype_o;
    for (int c = 0; c < 5; c++) begin
      step();
      chk("bp_usage", 128'(usage_o), 128'(3));
      chk("bp_iaddr", 128'(iaddr_o), 128'(held_iaddr));
      chk("bp_itype", 128'(itype_o), 128'(held_itype));
    end
    ready_i = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      chk("bp_drain", 128'(usage_o), 128'(2 - c));
    end

    // Overflow: usage 7, push two with a same-cycle pop
    ready_i = 1'b0;
    for (int c = 0; c < 7; c++) begin
      set_lane(0, rand_rec()); valid_i = 2'b01;
      step();
    end
    chk("ovf_pre_usage", 128'(usage_o), 128'(7));
    set_lane(0, rand_rec()); set_lane(1, rand_rec());
    valid_i = 2'b11; ready_i = 1'b1;
    step();
    valid_i = '0;
    chk("ovf_usage", 128'(usage_o), 128'(6));
    chk("ovf_pulse", 128'(overflow_o), 128'(1));
`ifdef TE_SERIALIZER_DROP_CNT_EN
    chk("ovf_drop_cnt", 128'(drop_cnt_o), 128'(2));
`endif
    step();
    chk("ovf_pulse_end", 128'(overflow_o), 128'(0));
    repeat (6) step();

    // Wrap-around: 20 single blocks streamed through
    for (int c = 0; c < 20; c++) begin
      r = rand_rec(); r.iaddr = XLEN'(c);
      set_lane(0, r); valid_i = 2'b01;
      step();
      chk("wrap_iaddr", 128'(iaddr_o), 128'(c));
      chk("wrap_valid", 128'(valid_o), 128'(1));
    end
    valid_i = '0;
    step();

    // Randomized traffic: mostly backlogged, then mostly draining
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < N; i++) set_lane(i, rand_rec());
      valid_i = N'($urandom);
      ready_i = (c < 300) ? ($urandom_range(0, 9) < 4) : ($urandom_range(0, 9) < 8);
      step();
    end
    valid_i = '0; ready_i = 1'b1;
    repeat (DEPTH + 2) step();

    // Asynchronous reset with five blocks queued
    ready_i = 1'b0;
    set_lane(0, rand_rec()); set_lane(1, rand_rec()); valid_i = 2'b11;
    step(); step();
    set_lane(0, rand_rec()); valid_i = 2'b01;
    step();
    valid_i = '0;
    chk("pre_rst_usage", 128'(usage_o), 128'(5));
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 128'(valid_o), 128'(0));
    chk("async_rst_usage", 128'(usage_o), 128'(0));
    @(negedge clk);
    rst_n = 1'b1; ready_i = 1'b1;
    step();
    chk("post_rst_valid", 128'(valid_o), 128'(0));
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/te_block_serializer.md
# te_block_serializer

Sits directly downstream of `multiple_retirement`. It accepts up to N parallel trace blocks per cycle, using the same fields as the retirement stage outputs. It buffers them in a circular queue and presents them one per cycle, in order, to a single-port trace encoder over a valid/ready handshake. It reports overflow when a cycle's blocks do not fit.

## Interface
- `N`, 1, number of input block lanes (≥1, ≤ DEPTH)
- `DEPTH`, 8, queue entries; power of two, ≥2
- `clk_i` input 1 clock
- `rst_ni` input 1 reset; one clock; reset is asynchronous and active-low
- `valid_i` input N per-lane block valid; lanes may be sparse
- `iretire_i` input N×IRETIRE_LEN retired-halfword count per lane
- `ilastsize_i` input N last-instruction size per lane
- `itype_i` input N×ITYPE_LEN block type per lane
- `cause_i` input N×CAUSE_LEN exception/interrupt cause per lane
- `tval_i` input N×XLEN trap value per lane
- `priv_i` input N×PRIV_LEN privilege level per lane
- `iaddr_i` input N×XLEN block start address per lane
- `valid_o` output 1 head block valid
- `ready_i` input 1 encoder accepts head block
- `iretire_o`, `ilastsize_o`, `itype_o`, `cause_o`, `tval_o`, `priv_o`, `iaddr_o` outputs: single-lane head block fields, same widths as one input lane
- `usage_o` output $clog2(DEPTH)+1 occupied entries
- `full_o` output 1 usage == DEPTH
- `overflow_o` output 1 one-cycle pulse: blocks were dropped in the previous cycle
- `drop_cnt_o` output 16 dropped-block count; present only with the macro in Configuration

All package widths come from `mure_pkg`.

## Operation
- Storage: DEPTH-entry array of block records; `wr_ptr`/`rd_ptr` of $clog2(DEPTH) bits wrap modulo DEPTH; `usage_q` of $clog2(DEPTH)+1 bits.
- Push: k = popcount(`valid_i`). Valid lanes are compacted in ascending lane index and written to `wr_ptr`, `wr_ptr`+1, …, `wr_ptr`+k−1 (mod DEPTH); then `wr_ptr` += k.
- Admission is all-or-nothing.
  - A cycle's blocks are accepted only if k ≤ DEPTH − `usage_q`.
  - A pop in the same cycle does not create space for that cycle's push.
  - On rejection, no lane is written; the drop is flagged and counted.
- Pop: when `valid_o` && `ready_i`, `rd_ptr` += 1.
- `usage_q` next = `usage_q` + (accepted ? k : 0) − pop.
- `valid_o` = (`usage_q` ≠ 0). Output fields come from entry `rd_ptr` when `valid_o`=1 and are driven to 0 when `valid_o`=0.
- Handshake:
  - While `valid_o`=1 and `ready_i`=0, all head fields stay stable.
  - `ready_i` may be high while `valid_o`=0; this has no effect.
- Ordering: blocks leave in arrival order; within a cycle, lower lane index leaves first. This keeps an exception block (itype 1/2) ahead of later same-cycle blocks.
- Simultaneous push and pop at any occupancy: both take effect. With `usage_q`=DEPTH, a pop frees a slot only from the next cycle.
- k=0 with `valid_i`=0 is a no-op; it is never a drop.

## Timing
- Reset values: pointers, `usage_q` and `usage_o` are 0; `valid_o`, `full_o` and `overflow_o` are 0; all head fields and `drop_cnt_o` are 0. Reset mid-operation discards all queued blocks immediately (asynchronously).
- Latency: a block written at edge t is visible on `valid_o` in the cycle after t. There is no combinational bypass from inputs to outputs.
- Throughput: 1 block/cycle out; up to N blocks/cycle in.
- `overflow_o`: registered, high for exactly the one cycle after each rejecting edge. Back-to-back drops keep it high continuously.
- `full_o` and `usage_o` reflect registered state. They never depend combinationally on `valid_i` or `ready_i`.

## Configuration
- `TE_SERIALIZER_DROP_CNT_EN` defined: `drop_cnt_o` exists.
  - It is a 16-bit counter incremented by k on every rejected cycle.
  - It saturates at 0xFFFF and clears only on reset.
- Not defined: the port and the counter are absent. `overflow_o` remains the only drop indication.

## Test plan
- Single push, N=2, DEPTH=8: `valid_i`=2'b10 with lane1 iaddr=0x8000_0010, itype=4, `ready_i`=1. Required response: next cycle `valid_o`=1, `iaddr_o`=0x8000_0010; following cycle `valid_o`=0, `usage_o`=0.
- Lane ordering: `valid_i`=2'b11 with lane0 itype=1, cause=0x2, tval=0xDEAD, and lane1 itype=4, iaddr=0x100. Required response: outputs itype 1 (cause 0x2, tval 0xDEAD), then itype 4 (iaddr 0x100), on consecutive cycles.
- Back-pressure: fill 3 blocks, `ready_i`=0 for 5 cycles. Required response: head fields constant, `usage_o`=3. Then raise `ready_i`: 3 blocks drain in 3 cycles in order.
- Overflow: DEPTH=8, `usage_o`=7, `ready_i`=1, push k=2. Required response: nothing written, `usage_o`=6 next cycle, `overflow_o` pulses once, `drop_cnt_o`=2 (macro on).
- Wrap-around: stream 20 single blocks with iaddr 0..19 at `ready_i`=1. Required response: output iaddr sequence 0..19 with no gaps after the first-cycle latency.
- Reset mid-operation: `usage_o`=5, assert `rst_ni`=0 asynchronously. Required response: `valid_o`=0 and `usage_o`=0 immediately, with no stale block after release.
